// File: rtl/avalon_bus_arbiter.sv
// Two-master, one-slave Avalon-style bus arbiter.
// Master 0 (CPU) and master 1 (secondary requester) share one slave port.
// Grants are round-robin, issued only from IDLE, and held for the whole
// transaction. A wait-cycle watchdog ends transactions the slave never completes.
module avalon_bus_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_mask,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_done,
    output logic                  m0_err,

    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_mask,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_done,
    output logic                  m1_err,

    output logic                  s_read,
    output logic                  s_write,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_mask,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic                  s_waitrequest
);

    localparam int MASK_W = DATA_W / 8;
    // Counter just wide enough to hold TIMEOUT; at least one bit when disabled.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req0, req1;
    logic              sel1;
    logic              g_req, g_read, g_write;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [MASK_W-1:0] g_mask;
    logic              x_done, x_err;
    logic [DATA_W-1:0] x_rdata;

    // State, round-robin pointer and wait counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;   // master 0 wins the first tie
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Arbitration, slave command muxing, completion/timeout/abort handling.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        s_read   = 1'b0;
        s_write  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_mask   = '0;
        m0_done  = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = '0;
        m1_done  = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = '0;

        x_done  = 1'b0;
        x_err   = 1'b0;
        x_rdata = '0;

        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;

        // Fields of whichever master currently owns the slave port.
        sel1    = (state_q == GNT1);
        g_req   = sel1 ? req1     : req0;
        g_read  = sel1 ? m1_read  : m0_read;
        g_write = sel1 ? m1_write : m0_write;
        g_addr  = sel1 ? m1_addr  : m0_addr;
        g_wdata = sel1 ? m1_wdata : m0_wdata;
        g_mask  = sel1 ? m1_mask  : m0_mask;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // On a tie the master that was not granted last wins.
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0, GNT1: begin
                // Write takes precedence when read and write are both high.
                s_write = g_write;
                s_read  = g_read & ~g_write;
                s_addr  = g_addr;
                s_wdata = g_wdata;
                s_mask  = g_mask;
                if (!g_req) begin
                    // Master withdrew: drop the grant silently.
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    x_done  = 1'b1;
                    x_rdata = s_rdata;
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_MAX)) begin
                    x_done  = 1'b1;
                    x_err   = 1'b1;
                    x_rdata = ERR_DATA;
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        m0_done  = x_done & ~sel1;
        m0_err   = x_err  & ~sel1;
        m0_rdata = (x_done && !sel1) ? x_rdata : '0;
        m1_done  = x_done & sel1;
        m1_err   = x_err  & sel1;
        m1_rdata = (x_done && sel1) ? x_rdata : '0;

        // While reset is held the in-flight command is dropped and nothing completes.
        if (!rst) begin
            s_read   = 1'b0;
            s_write  = 1'b0;
            s_addr   = '0;
            s_wdata  = '0;
            s_mask   = '0;
            m0_done  = 1'b0;
            m0_err   = 1'b0;
            m0_rdata = '0;
            m1_done  = 1'b0;
            m1_err   = 1'b0;
            m1_rdata = '0;
        end
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: scenario tasks plus a completion scoreboard.
module tb_avalon_bus_arbiter;

    localparam logic [31:0] ERR_D = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_mask, m1_mask;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic        s_read, s_write;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_mask;
    logic        s_waitrequest;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    avalon_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .ERR_DATA(ERR_D)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_mask(m0_mask), .m0_rdata(m0_rdata),
        .m0_done(m0_done), .m0_err(m0_err),
        .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_mask(m1_mask), .m1_rdata(m1_rdata),
        .m1_done(m1_done), .m1_err(m1_err),
        .s_read(s_read), .s_write(s_write), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_mask(s_mask), .s_rdata(s_rdata),
        .s_waitrequest(s_waitrequest)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done pulse must match the next expected completion.
    always @(negedge clk) begin
        if (m0_done || m1_done) begin
            total++;
            if (m0_done && m1_done) begin
                bad++;
                $display("FAIL sb_both_done: m0_done=%b m1_done=%b, required one", m0_done, m1_done);
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: done from m%0d with nothing expected", m1_done ? 1 : 0);
            end else begin
                e = sb.pop_front();
                if ((m1_done ? 1 : 0) != e.m
                    || (m1_done ? m1_rdata : m0_rdata) !== e.rdata
                    || (m1_done ? m1_err : m0_err) !== e.err) begin
                    bad++;
                    $display("FAIL sb_done: got m%0d rdata=%h err=%b, required m%0d rdata=%h err=%b",
                             m1_done ? 1 : 0, m1_done ? m1_rdata : m0_rdata,
                             m1_done ? m1_err : m0_err, e.m, e.rdata, e.err);
                end
            end
        end
        total++;
        if ((!m0_done && ({m0_err, m0_rdata} !== 33'h0))
            || (!m1_done && ({m1_err, m1_rdata} !== 33'h0))) begin
            bad++;
            $display("FAIL ungranted_outs: m0 err=%b rdata=%h m1 err=%b rdata=%h, required 0",
                     m0_err, m0_rdata, m1_err, m1_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        smp();
        total++;
        if ({s_read, s_write, s_addr, s_wdata, s_mask, m0_done, m1_done} !== 74'h0) begin
            bad++;
            $display("FAIL reset_outs: s_read=%b s_write=%b s_addr=%h m0_done=%b m1_done=%b, required all 0",
                     s_read, s_write, s_addr, m0_done, m1_done);
        end
        step();
        rst = 1'b1;
        smp();
    endtask

    task automatic test_single_read();
        step();
        m0_read = 1'b1; m0_addr = 32'h100; s_waitrequest = 1'b0; s_rdata = 32'hCAFEBABE;
        sb.push_back('{0, 32'hCAFEBABE, 1'b0});
        smp();
        total++;
        if ({s_read, m0_done} !== 2'b00) begin
            bad++; $display("FAIL sr_idle: s_read,m0_done=%b, required 00", {s_read, m0_done});
        end
        step();
        smp();
        total++;
        if ({s_read, s_write, m0_done, m0_err} !== 4'b1010 || s_addr !== 32'h100 || m0_rdata !== 32'hCAFEBABE) begin
            bad++;
            $display("FAIL sr_grant: rd,wr,done,err=%b addr=%h rdata=%h, required 1010 100 cafebabe",
                     {s_read, s_write, m0_done, m0_err}, s_addr, m0_rdata);
        end
        step();
        m0_read = 1'b0;
        smp();
        total++;
        if ({s_read, m0_done} !== 2'b00) begin
            bad++; $display("FAIL sr_after: s_read,m0_done=%b, required 00", {s_read, m0_done});
        end
    endtask

    task automatic test_contention();
        int served0 = 0, served1 = 0, cycles = 0;
        logic seen0 = 1'b0, seen1 = 1'b0, prevw = 1'b0, w;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        m0_read = 1'b1; m0_addr = 32'h200;
        m1_write = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h12345678; m1_mask = 4'b0011;
        s_waitrequest = 1'b0; s_rdata = 32'h11111111;
        sb.push_back('{0, 32'h11111111, 1'b0});
        sb.push_back('{1, 32'h11111111, 1'b0});
        smp();
        total++;
        if ({m0_done, m1_done, s_read, s_write} !== 4'b0000) begin
            bad++; $display("FAIL ct_idle: done0,done1,rd,wr=%b, required 0000", {m0_done, m1_done, s_read, s_write});
        end
        step();
        smp();
        total++;
        if ({s_read, s_write, m0_done, m1_done} !== 4'b1010 || s_addr !== 32'h200) begin
            bad++; $display("FAIL ct_m0_first: rd,wr,done0,done1=%b addr=%h, required 1010 200",
                            {s_read, s_write, m0_done, m1_done}, s_addr);
        end
        step();
        m0_read = 1'b0;
        smp();
        total++;
        if ({s_read, s_write, m1_done} !== 3'b000) begin
            bad++; $display("FAIL ct_gap: rd,wr,done1=%b, required 000", {s_read, s_write, m1_done});
        end
        step();
        smp();
        total++;
        if ({s_read, s_write, m1_done, m0_done} !== 4'b0110 || s_addr !== 32'h40
            || s_wdata !== 32'h12345678 || s_mask !== 4'b0011) begin
            bad++; $display("FAIL ct_m1_fields: rd,wr,done1,done0=%b addr=%h wdata=%h mask=%b, required 0110 40 12345678 0011",
                            {s_read, s_write, m1_done, m0_done}, s_addr, s_wdata, s_mask);
        end
        step();
        m1_write = 1'b0;
        smp();
        // Ten contended transactions; scoreboard order enforces 0,1,0,1...
        for (int i = 0; i < 10; i++) sb.push_back('{i % 2, 32'h11111111, 1'b0});
        while ((served0 + served1) < 10 && cycles < 200) begin
            step();
            cycles++;
            m0_read  = !seen0 && (served0 < 5);
            m1_write = !seen1 && (served1 < 5);
            w = !prevw && ($urandom_range(0, 2) == 0);
            s_waitrequest = w;
            prevw = w;
            smp();
            seen0 = m0_done;
            seen1 = m1_done;
            served0 += int'(m0_done);
            served1 += int'(m1_done);
        end
        step();
        m0_read = 1'b0; m1_write = 1'b0; s_waitrequest = 1'b0;
        smp();
        total++;
        if (served0 != 5 || served1 != 5) begin
            bad++; $display("FAIL ct_rr_count: served0=%0d served1=%0d in %0d cycles, required 5 and 5",
                            served0, served1, cycles);
        end
    endtask

    task automatic test_wait_stall();
        step();
        m1_write = 1'b1; m1_addr = 32'h80; m1_wdata = 32'hAABBCCDD; m1_mask = 4'hF;
        s_waitrequest = 1'b1; s_rdata = 32'h22222222;
        sb.push_back('{1, 32'h22222222, 1'b0});
        sb.push_back('{0, 32'h22222222, 1'b0});
        smp();
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 1) begin
                m0_read = 1'b1; m0_addr = 32'h300;
            end
            smp();
            total++;
            if ({s_read, s_write, m0_done, m1_done} !== 4'b0100 || s_addr !== 32'h80
                || s_wdata !== 32'hAABBCCDD || s_mask !== 4'hF) begin
                bad++; $display("FAIL ws_hold%0d: rd,wr,done0,done1=%b addr=%h wdata=%h, required 0100 80 aabbccdd",
                                i, {s_read, s_write, m0_done, m1_done}, s_addr, s_wdata);
            end
        end
        step();
        s_waitrequest = 1'b0;
        smp();
        total++;
        if ({s_write, m1_done, m0_done} !== 3'b110 || s_addr !== 32'h80) begin
            bad++; $display("FAIL ws_done: wr,done1,done0=%b addr=%h, required 110 80", {s_write, m1_done, m0_done}, s_addr);
        end
        step();
        m1_write = 1'b0;
        smp();
        total++;
        if ({s_read, m0_done} !== 2'b00) begin
            bad++; $display("FAIL ws_m0_waits: rd,done0=%b, required 00", {s_read, m0_done});
        end
        step();
        smp();
        total++;
        if ({s_read, m0_done} !== 2'b11 || s_addr !== 32'h300) begin
            bad++; $display("FAIL ws_m0_after: rd,done0=%b addr=%h, required 11 300", {s_read, m0_done}, s_addr);
        end
        step();
        m0_read = 1'b0;
        smp();
    endtask

    task automatic test_timeout();
        step();
        m0_read = 1'b1; m0_addr = 32'h400; s_waitrequest = 1'b1; s_rdata = 32'h33333333;
        sb.push_back('{0, ERR_D, 1'b1});
        sb.push_back('{1, 32'h33333333, 1'b0});
        smp();
        for (int g = 1; g <= 4; g++) begin
            step();
            if (g == 2) begin
                m1_read = 1'b1; m1_addr = 32'h500;
            end
            smp();
            total++;
            if ({s_read, m0_done, m0_err, m1_done} !== 4'b1000) begin
                bad++; $display("FAIL to_wait%0d: rd,done0,err0,done1=%b, required 1000", g, {s_read, m0_done, m0_err, m1_done});
            end
        end
        step();
        smp();
        total++;
        if ({s_read, m0_done, m0_err} !== 3'b111 || m0_rdata !== ERR_D) begin
            bad++; $display("FAIL to_fire: rd,done0,err0=%b rdata=%h, required 111 deadbeef", {s_read, m0_done, m0_err}, m0_rdata);
        end
        step();
        m0_read = 1'b0; s_waitrequest = 1'b0;
        smp();
        total++;
        if ({s_read, m1_done} !== 2'b00) begin
            bad++; $display("FAIL to_idle: rd,done1=%b, required 00", {s_read, m1_done});
        end
        step();
        smp();
        total++;
        if ({s_read, m1_done, m1_err} !== 3'b110 || s_addr !== 32'h500) begin
            bad++; $display("FAIL to_m1_next: rd,done1,err1=%b addr=%h, required 110 500", {s_read, m1_done, m1_err}, s_addr);
        end
        step();
        m1_read = 1'b0;
        smp();
    endtask

    task automatic test_abort();
        step();
        m1_write = 1'b1; m1_addr = 32'h600; s_waitrequest = 1'b1;
        smp();
        step();
        smp();
        total++;
        if ({s_write, m1_done} !== 2'b10) begin
            bad++; $display("FAIL ab_stall: wr,done1=%b, required 10", {s_write, m1_done});
        end
        step();
        m1_write = 1'b0;
        smp();
        total++;
        if ({s_write, m1_done} !== 2'b00) begin
            bad++; $display("FAIL ab_drop: wr,done1=%b, required 00", {s_write, m1_done});
        end
        step();
        m0_read = 1'b1; m0_addr = 32'h700; s_waitrequest = 1'b0; s_rdata = 32'h44444444;
        sb.push_back('{0, 32'h44444444, 1'b0});
        smp();
        total++;
        if ({s_read, s_write, m1_done} !== 3'b000) begin
            bad++; $display("FAIL ab_idle: rd,wr,done1=%b, required 000", {s_read, s_write, m1_done});
        end
        step();
        smp();
        total++;
        if ({s_read, m0_done} !== 2'b11 || s_addr !== 32'h700) begin
            bad++; $display("FAIL ab_next: rd,done0=%b addr=%h, required 11 700", {s_read, m0_done}, s_addr);
        end
        step();
        m0_read = 1'b0;
        smp();
    endtask

    task automatic test_reset_mid();
        step();
        m0_read = 1'b1; m0_addr = 32'h800; s_waitrequest = 1'b1;
        smp();
        step();
        smp();
        total++;
        if ({s_read, m0_done} !== 2'b10) begin
            bad++; $display("FAIL rm_stall: rd,done0=%b, required 10", {s_read, m0_done});
        end
        step();
        rst = 1'b0;
        smp();
        step();
        smp();
        total++;
        if ({s_read, s_write, s_addr, m0_done, m0_err, m1_done, m1_err} !== 38'h0) begin
            bad++; $display("FAIL rm_outs: rd=%b wr=%b addr=%h done0=%b done1=%b, required all 0",
                            s_read, s_write, s_addr, m0_done, m1_done);
        end
        step();
        rst = 1'b1;
        m1_read = 1'b1; m1_addr = 32'h900; s_waitrequest = 1'b0; s_rdata = 32'h55555555;
        sb.push_back('{0, 32'h55555555, 1'b0});
        sb.push_back('{1, 32'h55555555, 1'b0});
        smp();
        total++;
        if ({s_read, m0_done, m1_done} !== 3'b000) begin
            bad++; $display("FAIL rm_idle: rd,done0,done1=%b, required 000", {s_read, m0_done, m1_done});
        end
        step();
        smp();
        total++;
        if ({s_read, m0_done, m1_done} !== 3'b110 || s_addr !== 32'h800) begin
            bad++; $display("FAIL rm_tie_m0: rd,done0,done1=%b addr=%h, required 110 800", {s_read, m0_done, m1_done}, s_addr);
        end
        step();
        m0_read = 1'b0;
        smp();
        step();
        smp();
        total++;
        if ({s_read, m1_done} !== 2'b11 || s_addr !== 32'h900) begin
            bad++; $display("FAIL rm_m1: rd,done1=%b addr=%h, required 11 900", {s_read, m1_done}, s_addr);
        end
        step();
        m1_read = 1'b0;
        smp();
    endtask

    task automatic test_rw_both();
        step();
        m0_read = 1'b1; m0_write = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h55; m0_mask = 4'hF;
        s_waitrequest = 1'b0; s_rdata = 32'h66666666;
        sb.push_back('{0, 32'h66666666, 1'b0});
        smp();
        step();
        smp();
        total++;
        if ({s_read, s_write, m0_done} !== 3'b011 || s_wdata !== 32'h55 || s_addr !== 32'h10) begin
            bad++; $display("FAIL rw_both: rd,wr,done0=%b wdata=%h addr=%h, required 011 55 10",
                            {s_read, s_write, m0_done}, s_wdata, s_addr);
        end
        step();
        m0_read = 1'b0; m0_write = 1'b0;
        smp();
    endtask

    initial begin
        rst = 1'b0;
        m0_read = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0; m0_mask = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0; m1_mask = '0;
        s_rdata = '0; s_waitrequest = 1'b0;

        test_reset();
        test_single_read();
        test_contention();
        test_wait_stall();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_rw_both();

        step();
        smp();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_leftover: %0d completions never seen, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
